// File: rtl/riscv_lsu_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
interface riscv_lsu_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport master (
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i
  );
endinterface

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: IDLE/WAIT/DONE bus sequencer with lane steering and a WAIT timeout.
// Defining LSU_MISALIGN_TRAP_EN adds misalign_o and rejects misaligned H/HU/W accesses.
module riscv_lsu #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_req_o,
  output logic        bus_err_o,
  riscv_lsu_if.master mem
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} width_t;

  state_t      state_q, state_d;
  width_t      req_width;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic        trap;
  logic        start;

  logic [7:0]  cnt_q;
  logic [8:0]  cnt_inc;
  logic        timeout;

  logic        we_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic [31:0] rd_q;
  logic        err_q;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // Unsupported size codes fall through to a full-word access.
  always_comb begin
    case (core_size_i)
      3'd0, 3'd4: req_width = SZ_B;
      3'd1, 3'd5: req_width = SZ_H;
      default:    req_width = SZ_W;
    endcase
  end

  always_comb begin
    req_be = 4'b1111;
    req_wd = core_wd_i;
    if (core_we_i) begin
      case (req_width)
        SZ_B: begin
          req_be = 4'b0001 << core_addr_i[1:0];
          req_wd = {4{core_wd_i[7:0]}};
        end
        SZ_H: begin
          req_be = 4'b0011 << {core_addr_i[1], 1'b0};
          req_wd = {2{core_wd_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((req_width == SZ_H) && core_addr_i[0]) ||
                      ((req_width == SZ_W) && (core_addr_i[1:0] != 2'b00));
  assign trap = core_req_i && misaligned;
`else
  assign trap = 1'b0;
`endif
  assign start = core_req_i && !trap;

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign timeout = (cnt_inc == 9'(WAIT_MAX));

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // A ready in the same cycle as the timeout completes normally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_WAIT;
      S_WAIT:  if (mem.mem_ready_i || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt_q  <= 8'd0;
      we_q   <= 1'b0;
      size_q <= 3'd0;
      off_q  <= 2'd0;
      addr_q <= 30'd0;
      be_q   <= 4'd0;
      wd_q   <= 32'd0;
      rd_q   <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          we_q   <= core_we_i;
          size_q <= core_size_i;
          off_q  <= core_addr_i[1:0];
          addr_q <= core_addr_i[31:2];
          be_q   <= req_be;
          wd_q   <= req_wd;
          cnt_q  <= 8'd0;
        end
        S_WAIT: begin
          if (mem.mem_ready_i) begin
            if (!we_q) rd_q <= load_data;
          end else if (timeout) begin
            err_q <= 1'b1;
            rd_q  <= 32'd0;
          end else begin
            cnt_q <= cnt_inc[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    load_byte = mem.mem_rd_i[7:0];
      2'd1:    load_byte = mem.mem_rd_i[15:8];
      2'd2:    load_byte = mem.mem_rd_i[23:16];
      default: load_byte = mem.mem_rd_i[31:24];
    endcase
    load_half = off_q[1] ? mem.mem_rd_i[31:16] : mem.mem_rd_i[15:0];
    case (size_q)
      3'd0:    load_data = {{24{load_byte[7]}}, load_byte};
      3'd4:    load_data = {24'd0, load_byte};
      3'd1:    load_data = {{16{load_half[15]}}, load_half};
      3'd5:    load_data = {16'd0, load_half};
      default: load_data = mem.mem_rd_i;
    endcase
  end

  // Bus outputs are gated by reset so they drop the moment arstn_i falls.
  always_comb begin
    mem.mem_req_o    = 1'b0;
    mem.mem_we_o     = 1'b0;
    mem.mem_be_o     = 4'd0;
    mem.mem_addr_o   = 32'd0;
    mem.mem_wd_o     = 32'd0;
    core_stall_req_o = 1'b0;
    if (arstn_i) begin
      case (state_q)
        S_IDLE: if (start) begin
          mem.mem_req_o    = 1'b1;
          mem.mem_we_o     = core_we_i;
          mem.mem_be_o     = req_be;
          mem.mem_addr_o   = {core_addr_i[31:2], 2'b00};
          mem.mem_wd_o     = req_wd;
          core_stall_req_o = 1'b1;
        end
        S_WAIT: begin
          mem.mem_req_o    = 1'b1;
          mem.mem_we_o     = we_q;
          mem.mem_be_o     = be_q;
          mem.mem_addr_o   = {addr_q, 2'b00};
          mem.mem_wd_o     = wd_q;
          core_stall_req_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign core_rd_o = rd_q;
  assign bus_err_o = err_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o = arstn_i && (state_q == S_IDLE) && trap;
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: each access pushes its expected outcome, the DONE cycle pops and compares.
module tb_riscv_lsu;
  localparam int unsigned WAIT_MAX_TB = 16;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          stall;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_req_o;
  logic        bus_err_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  riscv_lsu_if bus ();

  riscv_lsu #(.WAIT_MAX(WAIT_MAX_TB)) dut (
    .clk_i            (clk_i),
    .arstn_i          (arstn_i),
    .core_req_i       (core_req_i),
    .core_we_i        (core_we_i),
    .core_size_i      (core_size_i),
    .core_addr_i      (core_addr_i),
    .core_wd_i        (core_wd_i),
    .core_rd_o        (core_rd_o),
    .core_stall_req_o (core_stall_req_o),
    .bus_err_o        (bus_err_o),
    .mem              (bus)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_o       (misalign_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb_queue[$];
  logic [31:0] last_rd = 32'd0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Expected outcome of one access, derived from the size code and byte address.
  function automatic exp_t model_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                        input logic [31:0] wd, input logic [31:0] rdata, input int ready_at);
    exp_t        e;
    logic [31:0] lane;
    bit          timed_out;
    timed_out = (ready_at < 0) || (ready_at >= int'(WAIT_MAX_TB));
    e.we    = we;
    e.addr  = addr & 32'hFFFF_FFFC;
    e.be    = 4'hF;
    e.wd    = wd;
    e.err   = timed_out;
    e.stall = timed_out ? int'(WAIT_MAX_TB) + 1 : ready_at + 2;
    if (we) begin
      if (size == 3'd0 || size == 3'd4) begin
        e.be = 4'b0001 << addr[1:0];
        e.wd = {24'd0, wd[7:0]} * 32'h0101_0101;
      end else if (size == 3'd1 || size == 3'd5) begin
        e.be = 4'b0011 << {addr[1], 1'b0};
        e.wd = {16'd0, wd[15:0]} * 32'h0001_0001;
      end
    end
    if (timed_out) begin
      last_rd = 32'd0;
    end else if (!we) begin
      case (size)
        3'd0: begin lane = rdata >> (8 * int'(addr[1:0])); last_rd = {{24{lane[7]}}, lane[7:0]}; end
        3'd4: begin lane = rdata >> (8 * int'(addr[1:0])); last_rd = {24'd0, lane[7:0]}; end
        3'd1: begin lane = rdata >> (16 * int'(addr[1])); last_rd = {{16{lane[15]}}, lane[15:0]}; end
        3'd5: begin lane = rdata >> (16 * int'(addr[1])); last_rd = {16'd0, lane[15:0]}; end
        default: last_rd = rdata;
      endcase
    end
    e.rd = last_rd;
    return e;
  endfunction

  // Entered and left just after a rising edge with the DUT in IDLE; ready_at < 0 means never ready.
  task automatic applyStimulus(input logic we, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rdata, input int ready_at);
    exp_t e;
    exp_t got;
    int   stall_count;
    int   cycles;
    bit   done;
    bit   err_early;
    e = model_access(we, size, addr, wd, rdata, ready_at);
    sb_queue.push_back(e);
    core_req_i = 1'b1; core_we_i = we; core_size_i = size; core_addr_i = addr; core_wd_i = wd;
    bus.mem_ready_i = 1'b0; bus.mem_rd_i = $urandom;
    @(negedge clk_i);
    checkOutput("idleReq", 32'(bus.mem_req_o), 32'd1);
    checkOutput("idleAddr", bus.mem_addr_o, e.addr);
    checkOutput("idleBe", 32'(bus.mem_be_o), 32'(e.be));
    checkOutput("idleWe", 32'(bus.mem_we_o), 32'(e.we));
    if (we) checkOutput("idleWd", bus.mem_wd_o, e.wd);
    stall_count = int'(core_stall_req_o);
    @(posedge clk_i); #1;
    // Request held high with scrambled fields: the captured copy must be used.
    core_addr_i = $urandom; core_wd_i = $urandom; core_size_i = 3'($urandom); core_we_i = ~we;
    done = 1'b0; err_early = 1'b0; cycles = 0;
    while (!done && cycles < 300) begin
      bus.mem_ready_i = (cycles == ready_at);
      bus.mem_rd_i    = (cycles == ready_at) ? rdata : $urandom;
      @(negedge clk_i);
      if (core_stall_req_o) begin
        stall_count++;
        if (bus_err_o) err_early = 1'b1;
        if (cycles == 0) begin
          checkOutput("waitReq", 32'(bus.mem_req_o), 32'd1);
          checkOutput("waitAddr", bus.mem_addr_o, e.addr);
          checkOutput("waitBe", 32'(bus.mem_be_o), 32'(e.be));
          checkOutput("waitWe", 32'(bus.mem_we_o), 32'(e.we));
          if (we) checkOutput("waitWd", bus.mem_wd_o, e.wd);
        end
      end else begin
        done = 1'b1;
        got = sb_queue.pop_front();
        checkOutput("doneRd", core_rd_o, got.rd);
        checkOutput("doneBusErr", 32'(bus_err_o), 32'(got.err));
        checkOutput("stallCycles", stall_count, got.stall);
        checkOutput("doneReq", 32'(bus.mem_req_o), 32'd0);
      end
      @(posedge clk_i); #1;
      cycles++;
    end
    if (!done) begin
      checkOutput("doneBound", 32'd0, 32'd1);
      void'(sb_queue.pop_front());
    end
    checkOutput("errInWait", 32'(err_early), 32'd0);
    core_req_i = 1'b0; bus.mem_ready_i = 1'b0;
    @(negedge clk_i);
    checkOutput("postReq", 32'(bus.mem_req_o), 32'd0);
    checkOutput("postStall", 32'(core_stall_req_o), 32'd0);
    checkOutput("postBusErr", 32'(bus_err_o), 32'd0);
    @(posedge clk_i); #1;
  endtask

  task automatic resetMidWait();
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h300;
    bus.mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    repeat (3) @(posedge clk_i);
    #2 arstn_i = 1'b0;
    #1;
    checkOutput("rstWaitReq", 32'(bus.mem_req_o), 32'd0);
    checkOutput("rstWaitStall", 32'(core_stall_req_o), 32'd0);
    checkOutput("rstWaitRd", core_rd_o, 32'd0);
    checkOutput("rstWaitAddr", bus.mem_addr_o, 32'd0);
    checkOutput("rstWaitBusErr", 32'(bus_err_o), 32'd0);
    @(negedge clk_i);
    checkOutput("rstHoldReq", 32'(bus.mem_req_o), 32'd0);
    core_req_i = 1'b0;
    arstn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("rstRelStall", 32'(core_stall_req_o), 32'd0);
      checkOutput("rstRelBusErr", 32'(bus_err_o), 32'd0);
    end
    last_rd = 32'd0;
    @(posedge clk_i); #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  sizes [5];
    logic [2:0]  sz;
    logic [31:0] a;
    sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    arstn_i = 1'b0; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
    core_addr_i = 32'd0; core_wd_i = 32'd0; bus.mem_ready_i = 1'b0; bus.mem_rd_i = 32'd0;
    #2;
    core_req_i = 1'b1; core_addr_i = 32'h100; core_size_i = 3'd2;
    #1;
    checkOutput("rstReq", 32'(bus.mem_req_o), 32'd0);
    checkOutput("rstStall", 32'(core_stall_req_o), 32'd0);
    checkOutput("rstRd", core_rd_o, 32'd0);
    checkOutput("rstBusErr", 32'(bus_err_o), 32'd0);
    checkOutput("rstBe", 32'(bus.mem_be_o), 32'd0);
    core_req_i = 1'b0;
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(posedge clk_i); #1;

    $display("[TB] directed accesses");
    applyStimulus(1'b0, 3'd2, 32'h0000_0100, 32'd0,          32'hDEAD_BEEF, 0);
    applyStimulus(1'b0, 3'd0, 32'h0000_0103, 32'd0,          32'h80FF_0011, 2);
    applyStimulus(1'b0, 3'd4, 32'h0000_0103, 32'd0,          32'h80FF_0011, 1);
    applyStimulus(1'b1, 3'd1, 32'h0000_0102, 32'h1234_ABCD,  32'h0,         0);
    applyStimulus(1'b1, 3'd0, 32'h0000_0101, 32'h0000_0055,  32'h0,         1);
    applyStimulus(1'b1, 3'd2, 32'h0000_0200, 32'hCAFE_F00D,  32'h0,         3);
    applyStimulus(1'b0, 3'd1, 32'h0000_0102, 32'd0,          32'h8001_7FFF, 0);
    applyStimulus(1'b0, 3'd5, 32'h0000_0100, 32'd0,          32'h8001_7FFF, 0);
    applyStimulus(1'b0, 3'd3, 32'h0000_0104, 32'd0,          32'h1357_9BDF, 0);
    applyStimulus(1'b0, 3'd2, 32'h0000_0108, 32'd0,          32'h1111_2222, -1);
    applyStimulus(1'b0, 3'd2, 32'h0000_010C, 32'd0,          32'hA5A5_5A5A, int'(WAIT_MAX_TB) - 1);

`ifdef LSU_MISALIGN_TRAP_EN
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h101;
    @(negedge clk_i);
    checkOutput("trapMisalign", 32'(misalign_o), 32'd1);
    checkOutput("trapReq", 32'(bus.mem_req_o), 32'd0);
    checkOutput("trapStall", 32'(core_stall_req_o), 32'd0);
    @(posedge clk_i); #1;
    core_req_i = 1'b0;
    @(negedge clk_i);
    checkOutput("trapIdle", 32'(misalign_o), 32'd0);
    checkOutput("trapIdleStall", 32'(core_stall_req_o), 32'd0);
    @(posedge clk_i); #1;
`else
    applyStimulus(1'b0, 3'd2, 32'h0000_0101, 32'd0,          32'h0BAD_F00D, 0);
    applyStimulus(1'b0, 3'd1, 32'h0000_0103, 32'd0,          32'hF00F_0001, 1);
`endif

    $display("[TB] random accesses");
    for (int n = 0; n < 20; n++) begin
      sz = sizes[$urandom_range(0, 4)];
      a  = $urandom;
      if (sz == 3'd1 || sz == 3'd5) a[0] = 1'b0;
      if (sz == 3'd2) a[1:0] = 2'b00;
      applyStimulus(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom, $urandom_range(0, 4));
    end

    $display("[TB] reset during WAIT");
    applyStimulus(1'b0, 3'd2, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0);
    resetMidWait();
    applyStimulus(1'b0, 3'd0, 32'h0000_0102, 32'd0, 32'h0042_0000, 0);

    checkOutput("sbEmpty", sb_queue.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
